rggen_register_access_arbiter: RTL and testbench
================================================

Name: rggen_register_access_arbiter

Overview:
Shares one register-map access port among N independent host requesters, e.g. a CPU bus adapter and a debug/JTAG adapter, over a single register block. Round-robin grant, one outstanding transaction at a time. Holds the downstream request stable until ready, returns the registered response to the granted requester only, and optionally terminates hung accesses with a timeout error.

Parameters:
REQUESTERS, 2, number of requesters N (1..8)
ADDRESS_WIDTH, 8, byte address width
BUS_WIDTH, 32, data width; BUS_WIDTH/8 strobe bits
TIMEOUT, 0, cycles of downstream valid without ready before forced error; 0 = disabled
TIMEOUT_WIDTH, 8, timeout counter width; TIMEOUT < 2**TIMEOUT_WIDTH

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-high reset
i_request_valid  input  N  per-requester request
i_request_write  input  N  1 = write, 0 = read
i_request_address  input  N*ADDRESS_WIDTH  packed, requester n at [n*ADDRESS_WIDTH+:ADDRESS_WIDTH]
i_request_write_data  input  N*BUS_WIDTH  packed write data
i_request_strobe  input  N*BUS_WIDTH/8  packed byte strobes
o_response_ack  output  N  one-cycle completion pulse, one-hot
o_response_status  output  2  0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR; valid with ack
o_response_read_data  output  BUS_WIDTH  valid with ack
o_valid  output  1  downstream request
o_write  output  1  downstream write
o_address  output  ADDRESS_WIDTH  downstream address
o_write_data  output  BUS_WIDTH  downstream write data
o_strobe  output  BUS_WIDTH/8  downstream strobe
i_ready  input  1  downstream ready
i_status  input  2  downstream status, sampled with i_ready
i_read_data  input  BUS_WIDTH  downstream read data, sampled with i_ready
o_grant  output  N  one-hot current owner, 0 when idle

Behaviour:
- Reset: state IDLE; o_valid, o_write, o_address, o_write_data, o_strobe, o_grant, o_response_ack, o_response_status, o_response_read_data = 0; priority pointer = 0.
- FSM has three states: IDLE, BUSY, ACK.
- IDLE: if any i_request_valid, pick the first set bit searching upward from the pointer, with wrap. Next cycle: BUSY, o_grant one-hot, o_valid=1, and that requester's payload registered onto the o_* outputs. Pointer = winner+1 mod N. No valid: stay IDLE.
- BUSY: o_* held constant, and later requester payload changes are ignored. On i_ready=1: capture i_status and i_read_data, drop o_valid, go to ACK.
- ACK: o_response_ack[winner]=1 for exactly one cycle. Then o_grant=0 and go to IDLE. The earliest next grant is visible 1 cycle after ACK.
- Min latency: request sampled at t; o_valid at t+1; ready at t+1; ack at t+2; next o_valid at t+4.
- Requester contract: hold valid and payload until its ack. A valid dropped before ack does not cancel; the transaction completes and ack is still issued.
- Ack and response data are registered outputs. Response data holds its last value between acks.
- Timeout (TIMEOUT>0): the counter clears on entering BUSY and increments each BUSY cycle with i_ready=0. When it reaches TIMEOUT: drop o_valid, status=SLVERR(2), read_data=0, go to ACK.
- i_ready in the same cycle the count reaches TIMEOUT: ready wins and the real status/data are returned.
- TIMEOUT=0: no counter logic, and the arbiter waits indefinitely.
- Non-winning requesters see no ack and stay pending. Round-robin bounds the wait to N-1 transactions.
- N=1: pointer is constant, and behaviour is otherwise identical.
- Reset asserted mid-transaction: all state and outputs return to reset values immediately (async). No ack is issued for the aborted access.

Test Plan:
- N=2, requester 0 reads addr 0x10, ready on first o_valid cycle with read_data 0xCAFE_0001 and status 0 -> o_address=0x10, o_write=0; ack[0] 2 cycles after request; read_data 0xCAFE_0001; status 0; ack[1] never.
- Both requesters valid continuously after reset, ready always 1 -> grant order 0,1,0,1; each ack one cycle wide; one transaction per 3 cycles.
- Requester 1 writes 0x1234_5678 with strobe 0x3, ready delayed 5 cycles; mid-wait the requester changes its payload to 0xFFFF_FFFF -> o_write_data stays 0x1234_5678 and o_strobe stays 0x3 for all 5 cycles; ack[1] 1 cycle after ready.
- TIMEOUT=4, ready never asserted -> o_valid high 4 cycles then low; ack with status 2, read_data 0. Repeat with ready on cycle 4 -> real status is returned.
- Requester 0 drops valid the cycle after grant -> ack[0] is still issued after ready, and the next grant goes to requester 1 if pending.
- Assert i_rst while in BUSY -> o_valid, o_grant and o_response_ack are 0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/rggen_register_access_arbiter.sv
// rtl/rggen_register_access_arbiter.sv - round-robin arbiter sharing one register access port among N requesters
// One outstanding access at a time; optional timeout converts a hung access into SLVERR.
module rggen_register_access_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int TIMEOUT       = 0,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [REQUESTERS-1:0]             i_request_valid,
  input  logic [REQUESTERS-1:0]             i_request_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_request_address,
  input  logic [REQUESTERS*BUS_WIDTH-1:0]   i_request_write_data,
  input  logic [REQUESTERS*BUS_WIDTH/8-1:0] i_request_strobe,
  output logic [REQUESTERS-1:0]             o_response_ack,
  output logic [1:0]                        o_response_status,
  output logic [BUS_WIDTH-1:0]              o_response_read_data,
  output logic                              o_valid,
  output logic                              o_write,
  output logic [ADDRESS_WIDTH-1:0]          o_address,
  output logic [BUS_WIDTH-1:0]              o_write_data,
  output logic [BUS_WIDTH/8-1:0]            o_strobe,
  input  logic                              i_ready,
  input  logic [1:0]                        i_status,
  input  logic [BUS_WIDTH-1:0]              i_read_data,
  output logic [REQUESTERS-1:0]             o_grant
);
  localparam int N  = REQUESTERS;
  localparam int SW = BUS_WIDTH / 8;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e                   state_q;
  logic [PW-1:0]            ptr_q;
  logic [PW-1:0]            ptr_d;
  logic [N-1:0]             grant_q;
  logic [N-1:0]             ack_q;
  logic                     valid_q;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [SW-1:0]            strobe_q;
  logic [1:0]               status_q;
  logic [BUS_WIDTH-1:0]     read_data_q;

  logic                     any_req;
  logic [N-1:0]             rot;
  logic [PW-1:0]            off;
  logic [PW:0]              win_sum;
  logic [PW-1:0]            win_idx;
  logic [N-1:0]             win_onehot;
  logic                     sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [BUS_WIDTH-1:0]     sel_write_data;
  logic [SW-1:0]            sel_strobe;
  logic                     timeout_hit;

  // Rotate the request vector so the pointer sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    any_req = |i_request_valid;
    rot     = N'({i_request_valid, i_request_valid} >> ptr_q);
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    win_sum = {1'b0, ptr_q} + {1'b0, off};
    if (win_sum >= (PW+1)'(N)) win_sum = win_sum - (PW+1)'(N);
    win_idx = win_sum[PW-1:0];
    if (win_idx == PW'(N - 1)) ptr_d = '0;
    else                       ptr_d = win_idx + 1'b1;
    win_onehot = N'(1) << win_idx;
  end

  always_comb begin
    sel_write      = 1'b0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_strobe     = '0;
    for (int i = 0; i < N; i++) begin
      if (win_onehot[i]) begin
        sel_write      = i_request_write[i];
        sel_address    = i_request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write_data = i_request_write_data[i*BUS_WIDTH +: BUS_WIDTH];
        sel_strobe     = i_request_strobe[i*SW +: SW];
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [TIMEOUT_WIDTH-1:0] count_q;
      logic [TIMEOUT_WIDTH-1:0] count_d;

      // Counts stalled BUSY cycles; zero outside BUSY so every access starts fresh.
      always_comb begin
        count_d = '0;
        if (state_q == BUSY && !i_ready) count_d = count_q + 1'b1;
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) count_q <= '0;
        else       count_q <= count_d;
      end

      assign timeout_hit = (state_q == BUSY) && !i_ready &&
                           (count_q == TIMEOUT_WIDTH'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      ack_q        <= '0;
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= '0;
      read_data_q  <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q      <= BUSY;
            grant_q      <= win_onehot;
            valid_q      <= 1'b1;
            write_q      <= sel_write;
            address_q    <= sel_address;
            write_data_q <= sel_write_data;
            strobe_q     <= sel_strobe;
            ptr_q        <= ptr_d;
          end
        end
        BUSY: begin
          if (i_ready) begin
            valid_q     <= 1'b0;
            status_q    <= i_status;
            read_data_q <= i_read_data;
            ack_q       <= grant_q;
            state_q     <= ACK;
          end else if (timeout_hit) begin
            valid_q     <= 1'b0;
            status_q    <= 2'd2;
            read_data_q <= '0;
            ack_q       <= grant_q;
            state_q     <= ACK;
          end
        end
        ACK: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_grant              = grant_q;
  assign o_response_ack       = ack_q;
  assign o_response_status    = status_q;
  assign o_response_read_data = read_data_q;
  assign o_valid              = valid_q;
  assign o_write              = write_q;
  assign o_address            = address_q;
  assign o_write_data         = write_data_q;
  assign o_strobe             = strobe_q;

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// tb/tb_rggen_register_access_arbiter.sv - scoreboard bench for rggen_register_access_arbiter
module tb_rggen_register_access_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rv[N];
  logic          rw[N];
  logic [AW-1:0] ra[N];
  logic [BW-1:0] rd[N];
  logic [SW-1:0] rs[N];

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_wdata;
  logic [N*SW-1:0] req_strobe;

  always_comb begin
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_strobe = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = rv[i];
      req_write[i]            = rw[i];
      req_addr[i*AW +: AW]    = ra[i];
      req_wdata[i*BW +: BW]   = rd[i];
      req_strobe[i*SW +: SW]  = rs[i];
    end
  end

  logic [N-1:0]  o_response_ack;
  logic [1:0]    o_response_status;
  logic [BW-1:0] o_response_read_data;
  logic          o_valid;
  logic          o_write;
  logic [AW-1:0] o_address;
  logic [BW-1:0] o_write_data;
  logic [SW-1:0] o_strobe;
  logic          i_ready;
  logic [1:0]    i_status;
  logic [BW-1:0] i_read_data;
  logic [N-1:0]  o_grant;

  rggen_register_access_arbiter #(
    .REQUESTERS(N), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT(TO), .TIMEOUT_WIDTH(8)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(req_valid), .i_request_write(req_write), .i_request_address(req_addr),
    .i_request_write_data(req_wdata), .i_request_strobe(req_strobe),
    .o_response_ack(o_response_ack), .o_response_status(o_response_status),
    .o_response_read_data(o_response_read_data),
    .o_valid(o_valid), .o_write(o_write), .o_address(o_address),
    .o_write_data(o_write_data), .o_strobe(o_strobe),
    .i_ready(i_ready), .i_status(i_status), .i_read_data(i_read_data),
    .o_grant(o_grant)
  );

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    logic [SW-1:0] s;
  } pay_t;

  typedef struct packed {
    logic [7:0]    win;
    logic [1:0]    st;
    logic [BW-1:0] dt;
  } rsp_t;

  pay_t exp_pay[N][$];
  rsp_t exp_rsp[$];

  int            tests = 0;
  int            fails = 0;
  bit            mon_en = 1'b0;
  int            rr = 0;
  logic [BW-1:0] last_data = '0;
  logic [N-1:0]  prv = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic requester(input int n, input int count);
    for (int k = 0; k < count; k++) begin
      pay_t p;
      int   to;
      bit   seen;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      p.w = 1'($urandom); p.a = AW'($urandom); p.d = $urandom; p.s = SW'($urandom);
      rv[n] = 1'b1; rw[n] = p.w; ra[n] = p.a; rd[n] = p.d; rs[n] = p.s;
      exp_pay[n].push_back(p);
      seen = 1'b0;
      to = 0;
      forever begin
        @(negedge clk);
        if (o_response_ack[n]) break;
        to++;
        if (to > 300) begin
          tests++; fails++;
          $display("FAIL req%0d_wait: got no ack after %0d cycles expected an ack", n, to);
          break;
        end
        if (o_grant[n] && !seen) begin
          seen = 1'b1;
          case ($urandom_range(0, 2))
            1: begin
              @(posedge clk); #1;
              rw[n] = ~rw[n]; ra[n] = AW'($urandom); rd[n] = 32'hFFFF_FFFF; rs[n] = ~rs[n];
            end
            2: begin
              @(posedge clk); #1;
              rv[n] = 1'b0; rd[n] = $urandom;
            end
            default: ;
          endcase
        end
      end
      @(posedge clk); #1;
      rv[n] = 1'b0;
    end
  endtask

  // Downstream responder plus grant/payload checks against a round-robin model.
  initial begin
    int            phase;
    int            bcnt;
    int            d;
    int            win;
    int            ntx;
    logic [1:0]    st;
    logic [BW-1:0] dt;
    rsp_t          r;
    phase = 0; bcnt = 0; d = 0; win = 0; ntx = 0; st = '0; dt = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (phase == 2) begin
          chk("valid_drop", 64'(o_valid), 64'(0));
          i_ready = 1'b0;
          phase = 0;
        end else begin
          if (phase == 0 && o_valid) begin
            win = -1;
            for (int i = 0; i < N; i++) begin
              if (win < 0 && prv[(rr + i) % N]) win = (rr + i) % N;
            end
            if (win < 0) begin
              tests++; fails++;
              $display("FAIL grant_no_req: got grant %b expected no grant", o_grant);
              win = 0;
            end
            chk("grant", 64'(o_grant), 64'(1) << win);
            rr = (win + 1) % N;
            phase = 1;
            bcnt = 0;
            case (ntx % 5)
              0:       d = TO - 1;
              1:       d = TO + 2;
              default: d = $urandom_range(0, 4);
            endcase
            ntx++;
            st = 2'($urandom);
            dt = $urandom;
          end
          if (phase == 1) begin
            chk("busy_valid", 64'(o_valid), 64'(1));
            chk("grant_hold", 64'(o_grant), 64'(1) << win);
            if (exp_pay[win].size() > 0) begin
              chk("o_write", 64'(o_write), 64'(exp_pay[win][0].w));
              chk("o_address", 64'(o_address), 64'(exp_pay[win][0].a));
              chk("o_write_data", 64'(o_write_data), 64'(exp_pay[win][0].d));
              chk("o_strobe", 64'(o_strobe), 64'(exp_pay[win][0].s));
            end else begin
              tests++; fails++;
              $display("FAIL payload: got grant to %0d expected a pending request", win);
            end
            if (bcnt == d) begin
              i_ready = 1'b1; i_status = st; i_read_data = dt;
              r.win = 8'(win); r.st = st; r.dt = dt;
              exp_rsp.push_back(r);
              phase = 2;
            end else if (bcnt == TO - 1) begin
              i_ready = 1'b0; i_status = 2'($urandom); i_read_data = $urandom;
              r.win = 8'(win); r.st = 2'd2; r.dt = '0;
              exp_rsp.push_back(r);
              phase = 2;
            end else begin
              i_ready = 1'b0; i_status = 2'($urandom); i_read_data = $urandom;
            end
            bcnt++;
          end
        end
      end
      prv = req_valid;
    end
  end

  // Response monitor: every ack pops the oldest expected response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_response_ack != '0) begin
          if (exp_rsp.size() == 0) begin
            tests++; fails++;
            $display("FAIL ack_unexpected: got ack %b expected none", o_response_ack);
          end else begin
            r = exp_rsp.pop_front();
            chk("ack", 64'(o_response_ack), 64'(1) << r.win);
            chk("rsp_status", 64'(o_response_status), 64'(r.st));
            chk("rsp_data", 64'(o_response_read_data), 64'(r.dt));
            last_data = r.dt;
            if (exp_pay[r.win].size() > 0) void'(exp_pay[r.win].pop_front());
          end
        end else begin
          chk("rdata_hold", 64'(o_response_read_data), 64'(last_data));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int to;
    rst = 1'b1;
    i_ready = 1'b0; i_status = '0; i_read_data = '0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0; rs[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_grant", 64'(o_grant), 64'(0));
    chk("rst_ack", 64'(o_response_ack), 64'(0));
    chk("rst_status", 64'(o_response_status), 64'(0));
    chk("rst_rdata", 64'(o_response_read_data), 64'(0));
    chk("rst_write", 64'(o_write), 64'(0));
    chk("rst_address", 64'(o_address), 64'(0));
    chk("rst_wdata", 64'(o_write_data), 64'(0));
    chk("rst_strobe", 64'(o_strobe), 64'(0));
    rst = 1'b0;

    @(posedge clk); #1;
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 8'h10;
    i_ready = 1'b1; i_status = 2'd0; i_read_data = 32'hCAFE_0001;
    @(negedge clk);
    chk("lat_t0_valid", 64'(o_valid), 64'(0));
    @(negedge clk);
    chk("lat_t1_valid", 64'(o_valid), 64'(1));
    chk("lat_t1_grant", 64'(o_grant), 64'(1));
    chk("lat_t1_address", 64'(o_address), 64'(8'h10));
    chk("lat_t1_write", 64'(o_write), 64'(0));
    @(negedge clk);
    chk("lat_t2_ack", 64'(o_response_ack), 64'(1));
    chk("lat_t2_rdata", 64'(o_response_read_data), 64'(32'hCAFE_0001));
    chk("lat_t2_status", 64'(o_response_status), 64'(0));
    chk("lat_t2_valid", 64'(o_valid), 64'(0));
    @(posedge clk); #1;
    rv[0] = 1'b0; i_ready = 1'b0; i_read_data = '0;
    @(negedge clk);
    chk("lat_t3_ack", 64'(o_response_ack), 64'(0));
    chk("lat_t3_grant", 64'(o_grant), 64'(0));

    rr = 1;
    last_data = 32'hCAFE_0001;
    mon_en = 1'b1;
    fork
      requester(0, 20);
      requester(1, 20);
      requester(2, 20);
    join
    repeat (12) @(negedge clk);
    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'(0));
    mon_en = 1'b0;

    @(posedge clk); #1;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'h44; rd[0] = 32'h1234_5678; rs[0] = 4'h3;
    i_ready = 1'b0;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!o_valid && to < 10);
    chk("rst_busy_grant", 64'(o_grant), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_valid", 64'(o_valid), 64'(0));
    chk("rst_busy_grant0", 64'(o_grant), 64'(0));
    chk("rst_busy_ack", 64'(o_response_ack), 64'(0));
    rv[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", 64'(o_grant), 64'(1));
    chk("post_rst_ack", 64'(o_response_ack), 64'(0));
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    i_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
